// File: rtl/mem_pkg.sv
// Shared encodings for the memory-access stage: access sizes, byte enables,
// FSM states and the registered request / MEM-WB bundles.
package mem_pkg;
   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;

   localparam logic [3:0] BE_B0  = 4'b0001;
   localparam logic [3:0] BE_LO  = 4'b0011;
   localparam logic [3:0] BE_HI  = 4'b1100;
   localparam logic [3:0] BE_ALL = 4'b1111;

   typedef enum logic {IDLE = 1'b0, REQ = 1'b1} state_e;

   typedef struct packed {
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  be;
   } dmem_cmd_t;

   typedef struct packed {
      logic [31:0] alu;
      logic [31:0] data;
      logic [4:0]  rd;
      logic        mtr;
      logic        wb;
   } memwb_t;
endpackage

// File: rtl/mem_stage_if.sv
// Data-memory req/ack port; master is the pipeline stage, slave the memory.
interface mem_stage_if;
   logic        dmem_req;
   logic        dmem_we;
   logic [31:0] dmem_addr;
   logic [31:0] dmem_wdata;
   logic [3:0]  dmem_be;
   logic        dmem_ack;
   logic [31:0] dmem_rdata;

   modport master (output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
                   input  dmem_ack, dmem_rdata);
   modport slave  (input  dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
                   output dmem_ack, dmem_rdata);
endinterface

// File: rtl/mem_lane_align.sv
// Byte-lane steering: store enables/replication, load extraction with
// sign/zero extension, and misalignment detection.
module mem_lane_align
   import mem_pkg::*;
(
   input  logic [1:0]  off,
   input  logic [1:0]  size,
   input  logic        sext,
   input  logic        store,
   input  logic [31:0] sdata,
   input  logic [31:0] rdata,
   output logic [3:0]  be,
   output logic [31:0] wdata,
   output logic [31:0] ldata,
   output logic        misalign
);
   logic [7:0]  lane_b;
   logic [15:0] lane_h;

   assign lane_b = rdata[{off, 3'b000} +: 8];
   assign lane_h = rdata[{off[1], 4'b0000} +: 16];

   always_comb begin
      be       = BE_ALL;
      wdata    = sdata;
      ldata    = rdata;
      misalign = 1'b0;
      case (size)
         SZ_BYTE: begin
            be    = BE_B0 << off;
            wdata = {4{sdata[7:0]}};
            ldata = {{24{sext & lane_b[7]}}, lane_b};
         end
         SZ_HALF: begin
            be       = off[1] ? BE_HI : BE_LO;
            wdata    = {2{sdata[15:0]}};
            ldata    = {{16{sext & lane_h[15]}}, lane_h};
            misalign = off[0];
         end
         default: misalign = |off;  // size 11 behaves as word
      endcase
      // loads read the whole word and drive no store data
      if (!store) begin
         be    = BE_ALL;
         wdata = '0;
      end
   end
endmodule

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: issues loads/stores over req/ack, stalls
// upstream while outstanding, aborts on watchdog expiry, registers MEM/WB.
module mem_stage
   import mem_pkg::*;
#(
   parameter int TIMEOUT = 16,
   parameter int TO_W    = 5
) (
   input  logic        CLK,
   input  logic        RESET,
   input  logic        valid_IN,
   input  logic [31:0] aluResult1,
   input  logic [31:0] data_write1,
   input  logic [4:0]  writeRegister1,
   input  logic        do_writeback1,
   input  logic        MemtoReg1,
   input  logic        MemRead1,
   input  logic        MemWrite1,
   input  logic [1:0]  mem_size1,
   input  logic        mem_signed1,
   output logic        STALL_OUT,
   mem_stage_if.master dmem,
   output logic [31:0] aluResult1_OUT,
   output logic [31:0] Data_input1_OUT,
   output logic [4:0]  writeRegister1_OUT,
   output logic        MemtoReg1_OUT,
   output logic        do_writeback1_OUT,
   output logic        misalign_OUT,
   output logic        bus_error_OUT
);
   localparam logic [TO_W-1:0] TERM = (TIMEOUT == 0) ? '0 : TO_W'(TIMEOUT - 1);

   state_e          state, nxt;
   logic [TO_W-1:0] count;
   dmem_cmd_t       cmd;
   memwb_t          mw;
   logic            memop, ack, term;
   logic            stall, misalign, bus_err, accept, cap;
   logic [3:0]      be_w;
   logic [31:0]     wdata_w, ldata_w;
   logic            mis_w;

   assign memop = valid_IN & (MemRead1 | MemWrite1);
   assign ack   = dmem.dmem_ack;
   assign term  = (TIMEOUT != 0) && (count == TERM);

   mem_lane_align u_align (
      .off(aluResult1[1:0]), .size(mem_size1), .sext(mem_signed1),
      .store(MemWrite1), .sdata(data_write1), .rdata(dmem.dmem_rdata),
      .be(be_w), .wdata(wdata_w), .ldata(ldata_w), .misalign(mis_w)
   );

   always_ff @(posedge CLK or posedge RESET)
      if (RESET) state <= IDLE;
      else       state <= nxt;

   // cap: MEM/WB takes the live inputs; otherwise it takes a bubble
   always_comb begin
      nxt      = state;
      stall    = 1'b0;
      misalign = 1'b0;
      bus_err  = 1'b0;
      accept   = 1'b0;
      cap      = 1'b0;
      case (state)
         IDLE:
            if (!memop)     cap = 1'b1;
            else if (mis_w) misalign = 1'b1;
            else begin
               stall  = 1'b1;
               accept = 1'b1;
               nxt    = REQ;
            end
         REQ:
            if (ack) begin
               cap = 1'b1;
               nxt = IDLE;
            end else if (term) begin
               bus_err = 1'b1;
               nxt     = IDLE;
            end else stall = 1'b1;
         default: nxt = IDLE;
      endcase
   end

   always_ff @(posedge CLK or posedge RESET)
      if (RESET)                      count <= '0;
      else if (accept)                count <= '0;
      else if (state == REQ && !ack)  count <= count + 1'b1;

   always_ff @(posedge CLK or posedge RESET)
      if (RESET)       cmd <= '0;
      else if (accept) cmd <= '{we: MemWrite1, addr: {aluResult1[31:2], 2'b00},
                                wdata: wdata_w, be: be_w};

   always_ff @(posedge CLK or posedge RESET)
      if (RESET) mw <= '0;
      else if (cap) begin
         mw.alu  <= aluResult1;
         mw.rd   <= writeRegister1;
         mw.wb   <= do_writeback1 & valid_IN;
         mw.mtr  <= MemtoReg1 & valid_IN;
         mw.data <= (state == REQ && MemRead1) ? ldata_w : '0;
      end else mw <= '0;

   // combinational strobes are masked so every output reads 0 during reset
   assign STALL_OUT     = stall & ~RESET;
   assign misalign_OUT  = misalign & ~RESET;
   assign bus_error_OUT = bus_err & ~RESET;

   assign dmem.dmem_req   = (state == REQ);
   assign dmem.dmem_we    = cmd.we;
   assign dmem.dmem_addr  = cmd.addr;
   assign dmem.dmem_wdata = cmd.wdata;
   assign dmem.dmem_be    = cmd.be;

   assign aluResult1_OUT     = mw.alu;
   assign Data_input1_OUT    = mw.data;
   assign writeRegister1_OUT = mw.rd;
   assign MemtoReg1_OUT      = mw.mtr;
   assign do_writeback1_OUT  = mw.wb;
endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed scenarios plus randomized
// accesses checked against a byte-arithmetic reference model.
module tb_mem_stage;
   logic        CLK = 1'b0;
   logic        RESET;
   logic        valid_IN, do_writeback1, MemtoReg1, MemRead1, MemWrite1, mem_signed1;
   logic [31:0] aluResult1, data_write1;
   logic [4:0]  writeRegister1;
   logic [1:0]  mem_size1;
   logic        STALL_OUT, MemtoReg1_OUT, do_writeback1_OUT, misalign_OUT, bus_error_OUT;
   logic [31:0] aluResult1_OUT, Data_input1_OUT;
   logic [4:0]  writeRegister1_OUT;

   mem_stage_if dmem_bus ();

   mem_stage #(.TIMEOUT(16), .TO_W(5)) dut (
      .CLK(CLK), .RESET(RESET), .valid_IN(valid_IN), .aluResult1(aluResult1),
      .data_write1(data_write1), .writeRegister1(writeRegister1),
      .do_writeback1(do_writeback1), .MemtoReg1(MemtoReg1), .MemRead1(MemRead1),
      .MemWrite1(MemWrite1), .mem_size1(mem_size1), .mem_signed1(mem_signed1),
      .STALL_OUT(STALL_OUT), .dmem(dmem_bus),
      .aluResult1_OUT(aluResult1_OUT), .Data_input1_OUT(Data_input1_OUT),
      .writeRegister1_OUT(writeRegister1_OUT), .MemtoReg1_OUT(MemtoReg1_OUT),
      .do_writeback1_OUT(do_writeback1_OUT), .misalign_OUT(misalign_OUT),
      .bus_error_OUT(bus_error_OUT)
   );

   always #5 CLK = ~CLK;

   int total = 0;
   int bad   = 0;

   // ---------------- reference model ----------------
   function automatic int nbytes(input logic [1:0] sz);
      return (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
   endfunction

   function automatic logic [31:0] mask_of(input int n);
      return (n == 4) ? 32'hFFFF_FFFF : ((32'h1 << (8 * n)) - 32'h1);
   endfunction

   function automatic logic [3:0] exp_be(input bit st, input logic [1:0] sz, input logic [31:0] a);
      int n;
      if (!st) return 4'hF;
      n = nbytes(sz);
      return 4'(((1 << n) - 1) << (a % 4));
   endfunction

   function automatic logic [31:0] exp_wdata(input bit st, input logic [1:0] sz, input logic [31:0] d);
      int n;
      logic [31:0] w;
      if (!st) return 32'h0;
      n = nbytes(sz);
      w = 32'h0;
      for (int i = 0; i < 4; i += n) w |= (d & mask_of(n)) << (8 * i);
      return w;
   endfunction

   function automatic logic [31:0] exp_load(input logic [1:0] sz, input bit sg,
                                            input logic [31:0] a, input logic [31:0] rd);
      int n, off;
      logic [31:0] v;
      n   = nbytes(sz);
      off = (n == 4) ? 0 : int'(a % 4);
      v   = (rd >> (8 * off)) & mask_of(n);
      if (sg && n < 4 && v[8 * n - 1]) v |= ~mask_of(n);
      return v;
   endfunction

   function automatic bit is_misaligned(input logic [1:0] sz, input logic [31:0] a);
      return (a % nbytes(sz)) != 0;
   endfunction

   // ---------------- stimulus helpers ----------------
   task automatic drive(input bit v, input logic [31:0] alu, input logic [31:0] wd,
                        input logic [4:0] rd, input bit wb, input bit mtr, input bit rdn,
                        input bit wrn, input logic [1:0] sz, input bit sg);
      valid_IN = v; aluResult1 = alu; data_write1 = wd; writeRegister1 = rd;
      do_writeback1 = wb; MemtoReg1 = mtr; MemRead1 = rdn; MemWrite1 = wrn;
      mem_size1 = sz; mem_signed1 = sg;
   endtask

   task automatic bubble();
      drive(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0);
   endtask

   // Runs one instruction already on the inputs (called at posedge+1) until the
   // stage stops stalling. Memory acks in REQ cycle ack_at (0 = never).
   // Returns at posedge+1 right after MEM/WB captured the result.
   task automatic run_op(input int ack_at, input logic [31:0] rdata,
                         output int stall_cnt, output int req_cnt,
                         output bit buserr, output bit mis, output bit unstable,
                         output logic [31:0] addr_s, output logic [31:0] wdata_s,
                         output logic [3:0] be_s, output logic we_s, output bit to);
      bit done;
      stall_cnt = 0; req_cnt = 0; buserr = 0; mis = 0; unstable = 0;
      addr_s = 'x; wdata_s = 'x; be_s = 'x; we_s = 1'bx; to = 1; done = 0;
      for (int cyc = 0; cyc < 40 && !done; cyc++) begin
         if (dmem_bus.dmem_req && (req_cnt + 1 == ack_at)) begin
            dmem_bus.dmem_ack = 1'b1; dmem_bus.dmem_rdata = rdata;
         end else if (!dmem_bus.dmem_req) begin
            dmem_bus.dmem_ack = ($urandom % 4 == 0);  // stray ack in IDLE
            dmem_bus.dmem_rdata = $urandom;
         end else begin
            dmem_bus.dmem_ack = 1'b0; dmem_bus.dmem_rdata = $urandom;
         end
         @(negedge CLK);
         if (STALL_OUT) stall_cnt++;
         if (bus_error_OUT) buserr = 1;
         if (misalign_OUT) mis = 1;
         if (dmem_bus.dmem_req) begin
            if (req_cnt > 0 && (addr_s !== dmem_bus.dmem_addr || wdata_s !== dmem_bus.dmem_wdata ||
                                be_s !== dmem_bus.dmem_be || we_s !== dmem_bus.dmem_we))
               unstable = 1;
            req_cnt++;
            addr_s = dmem_bus.dmem_addr; wdata_s = dmem_bus.dmem_wdata;
            be_s = dmem_bus.dmem_be; we_s = dmem_bus.dmem_we;
         end
         done = !STALL_OUT;
         @(posedge CLK); #1;
         dmem_bus.dmem_ack = 1'b0;
         if (done) to = 0;
      end
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      RESET = 1'b1; bubble();
      dmem_bus.dmem_ack = 1'b0; dmem_bus.dmem_rdata = 32'h0;
      repeat (2) @(posedge CLK);
      #1;
      total++; if (dmem_bus.dmem_req !== 1'b0) begin bad++; $display("FAIL reset_req got=%b want=0", dmem_bus.dmem_req); end
      total++; if (STALL_OUT !== 1'b0) begin bad++; $display("FAIL reset_stall got=%b want=0", STALL_OUT); end
      total++; if ({dmem_bus.dmem_we, dmem_bus.dmem_addr, dmem_bus.dmem_wdata, dmem_bus.dmem_be} !== 69'h0)
         begin bad++; $display("FAIL reset_bus addr=%h wdata=%h be=%b want 0", dmem_bus.dmem_addr, dmem_bus.dmem_wdata, dmem_bus.dmem_be); end
      total++; if ({aluResult1_OUT, Data_input1_OUT, writeRegister1_OUT, MemtoReg1_OUT, do_writeback1_OUT} !== 71'h0)
         begin bad++; $display("FAIL reset_memwb alu=%h data=%h rd=%0d want 0", aluResult1_OUT, Data_input1_OUT, writeRegister1_OUT); end
      total++; if ({misalign_OUT, bus_error_OUT} !== 2'b00) begin bad++; $display("FAIL reset_pulses got=%b want=00", {misalign_OUT, bus_error_OUT}); end
      RESET = 1'b0;
      @(posedge CLK); #1;
   endtask

   task automatic test_alu_op();
      int sc, rc; bit be_, mi, un, to; logic [31:0] a, w; logic [3:0] b; logic we;
      drive(1'b1, 32'h1234, 32'h0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 2'b10, 1'b0);
      run_op(1, 32'h0, sc, rc, be_, mi, un, a, w, b, we, to);
      total++; if (to || sc != 0) begin bad++; $display("FAIL alu_stall got=%0d want=0", sc); end
      total++; if (aluResult1_OUT !== 32'h1234) begin bad++; $display("FAIL alu_result got=%h want=00001234", aluResult1_OUT); end
      total++; if (writeRegister1_OUT !== 5'd5) begin bad++; $display("FAIL alu_rd got=%0d want=5", writeRegister1_OUT); end
      total++; if (do_writeback1_OUT !== 1'b1) begin bad++; $display("FAIL alu_wb got=%b want=1", do_writeback1_OUT); end
      total++; if (Data_input1_OUT !== 32'h0 || rc != 0) begin bad++; $display("FAIL alu_data got=%h req=%0d want 0/0", Data_input1_OUT, rc); end
      bubble();
   endtask

   task automatic test_signed_byte_load();
      int sc, rc; bit be_, mi, un, to; logic [31:0] a, w; logic [3:0] b; logic we;
      drive(1'b1, 32'h1003, 32'h0, 5'd7, 1'b1, 1'b1, 1'b1, 1'b0, 2'b00, 1'b1);
      run_op(1, 32'h80AABBCC, sc, rc, be_, mi, un, a, w, b, we, to);
      total++; if (to || sc != 1) begin bad++; $display("FAIL lb_stall got=%0d want=1", sc); end
      total++; if (a !== 32'h1000) begin bad++; $display("FAIL lb_addr got=%h want=00001000", a); end
      total++; if (b !== 4'b1111 || we !== 1'b0) begin bad++; $display("FAIL lb_be got=%b we=%b want=1111/0", b, we); end
      total++; if (Data_input1_OUT !== 32'hFFFFFF80) begin bad++; $display("FAIL lb_data got=%h want=ffffff80", Data_input1_OUT); end
      total++; if ({MemtoReg1_OUT, do_writeback1_OUT, writeRegister1_OUT} !== {2'b11, 5'd7})
         begin bad++; $display("FAIL lb_ctrl got=%b%b rd=%0d want 11/7", MemtoReg1_OUT, do_writeback1_OUT, writeRegister1_OUT); end
      bubble();
   endtask

   task automatic test_half_store();
      int sc, rc; bit be_, mi, un, to; logic [31:0] a, w; logic [3:0] b; logic we;
      drive(1'b1, 32'h2002, 32'h1234BEEF, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b01, 1'b0);
      run_op(4, 32'h0, sc, rc, be_, mi, un, a, w, b, we, to);
      total++; if (to || sc != 4) begin bad++; $display("FAIL sh_stall got=%0d want=4", sc); end
      total++; if (w !== 32'hBEEFBEEF) begin bad++; $display("FAIL sh_wdata got=%h want=beefbeef", w); end
      total++; if (b !== 4'b1100 || we !== 1'b1 || a !== 32'h2000) begin bad++; $display("FAIL sh_bus be=%b we=%b addr=%h want 1100/1/00002000", b, we, a); end
      total++; if (un || rc != 4) begin bad++; $display("FAIL sh_stable unstable=%0d req=%0d want 0/4", un, rc); end
      total++; if (do_writeback1_OUT !== 1'b0 || Data_input1_OUT !== 32'h0) begin bad++; $display("FAIL sh_wb got=%b data=%h want 0/0", do_writeback1_OUT, Data_input1_OUT); end
      bubble();
   endtask

   task automatic test_misalign();
      int sc, rc; bit be_, mi, un, to; logic [31:0] a, w; logic [3:0] b; logic we;
      drive(1'b1, 32'h3001, 32'h0, 5'd9, 1'b1, 1'b1, 1'b1, 1'b0, 2'b10, 1'b0);
      run_op(1, 32'h0, sc, rc, be_, mi, un, a, w, b, we, to);
      total++; if (rc != 0) begin bad++; $display("FAIL mis_req got=%0d want=0", rc); end
      total++; if (!mi) begin bad++; $display("FAIL mis_pulse got=0 want=1"); end
      total++; if (to || sc != 0) begin bad++; $display("FAIL mis_stall got=%0d want=0", sc); end
      total++; if ({aluResult1_OUT, Data_input1_OUT, writeRegister1_OUT, MemtoReg1_OUT, do_writeback1_OUT} !== 71'h0)
         begin bad++; $display("FAIL mis_bubble alu=%h rd=%0d wb=%b want 0", aluResult1_OUT, writeRegister1_OUT, do_writeback1_OUT); end
      bubble();
      #1;
      total++; if (misalign_OUT !== 1'b0) begin bad++; $display("FAIL mis_clear got=%b want=0", misalign_OUT); end
   endtask

   task automatic test_timeout();
      int sc, rc; bit be_, mi, un, to; logic [31:0] a, w; logic [3:0] b; logic we;
      drive(1'b1, 32'h4000, 32'h0, 5'd3, 1'b1, 1'b1, 1'b1, 1'b0, 2'b10, 1'b0);
      run_op(0, 32'h0, sc, rc, be_, mi, un, a, w, b, we, to);
      total++; if (to || !be_) begin bad++; $display("FAIL to_buserr got=%0d timeout=%0d want 1", be_, to); end
      total++; if (rc != 16) begin bad++; $display("FAIL to_reqcycles got=%0d want=16", rc); end
      total++; if (sc != 16) begin bad++; $display("FAIL to_stall got=%0d want=16", sc); end
      total++; if (dmem_bus.dmem_req !== 1'b0) begin bad++; $display("FAIL to_reqdrop got=%b want=0", dmem_bus.dmem_req); end
      total++; if ({do_writeback1_OUT, MemtoReg1_OUT, Data_input1_OUT} !== 34'h0)
         begin bad++; $display("FAIL to_bubble wb=%b mtr=%b data=%h want 0", do_writeback1_OUT, MemtoReg1_OUT, Data_input1_OUT); end
      bubble();
      // ack on the terminal cycle wins
      drive(1'b1, 32'h4004, 32'h0, 5'd4, 1'b1, 1'b1, 1'b1, 1'b0, 2'b10, 1'b0);
      run_op(16, 32'hCAFEF00D, sc, rc, be_, mi, un, a, w, b, we, to);
      total++; if (to || be_) begin bad++; $display("FAIL to_ack_buserr got=%0d want=0", be_); end
      total++; if (Data_input1_OUT !== 32'hCAFEF00D || do_writeback1_OUT !== 1'b1)
         begin bad++; $display("FAIL to_ack_data got=%h wb=%b want cafef00d/1", Data_input1_OUT, do_writeback1_OUT); end
      total++; if (rc != 16) begin bad++; $display("FAIL to_ack_req got=%0d want=16", rc); end
      bubble();
   endtask

   task automatic test_async_reset();
      int sc, rc; bit be_, mi, un, to; logic [31:0] a, w; logic [3:0] b; logic we;
      drive(1'b1, 32'h5008, 32'h0, 5'd6, 1'b1, 1'b1, 1'b1, 1'b0, 2'b10, 1'b0);
      dmem_bus.dmem_ack = 1'b0;
      repeat (3) @(posedge CLK);
      #3;
      total++; if (dmem_bus.dmem_req !== 1'b1) begin bad++; $display("FAIL ar_inreq got=%b want=1", dmem_bus.dmem_req); end
      RESET = 1'b1;
      #1;
      total++; if (dmem_bus.dmem_req !== 1'b0 || STALL_OUT !== 1'b0) begin bad++; $display("FAIL ar_req req=%b stall=%b want 0/0", dmem_bus.dmem_req, STALL_OUT); end
      total++; if ({dmem_bus.dmem_addr, dmem_bus.dmem_be, aluResult1_OUT, do_writeback1_OUT} !== 69'h0)
         begin bad++; $display("FAIL ar_outs addr=%h be=%b alu=%h want 0", dmem_bus.dmem_addr, dmem_bus.dmem_be, aluResult1_OUT); end
      bubble();
      @(posedge CLK); #1;
      RESET = 1'b0;
      @(posedge CLK); #1;
      drive(1'b1, 32'h600A, 32'h0, 5'd8, 1'b1, 1'b1, 1'b1, 1'b0, 2'b01, 1'b0);
      run_op(2, 32'h8001_7777, sc, rc, be_, mi, un, a, w, b, we, to);
      total++; if (to || Data_input1_OUT !== 32'h0000_8001 || sc != 2)
         begin bad++; $display("FAIL ar_fresh data=%h stall=%0d want 00008001/2", Data_input1_OUT, sc); end
      bubble();
   endtask

   task automatic test_random();
      int sc, rc, kind, n, ack_at, exp_sc;
      bit be_, mi, un, to, v, rdn, wrn, wb, mtr, sg, memop, misal;
      logic [31:0] a, w, addr, d, rdat; logic [3:0] b; logic we; logic [1:0] sz; logic [4:0] rd;
      for (int it = 0; it < 60; it++) begin
         kind = $urandom % 4;
         sz = 2'($urandom % 4); n = nbytes(sz);
         addr = $urandom; d = $urandom; rdat = $urandom; rd = 5'($urandom);
         wb = $urandom % 2; mtr = $urandom % 2; sg = $urandom % 2;
         if ($urandom % 4 != 0) addr = addr & ~32'(n - 1);
         v   = (kind != 0);
         rdn = (kind == 2) || (kind == 0 && $urandom % 2 == 1);
         wrn = (kind == 3);
         ack_at = ($urandom % 10 == 0) ? 0 : 1 + ($urandom % 4);
         memop = v && (rdn || wrn);
         misal = memop && is_misaligned(sz, addr);
         drive(v, addr, d, rd, wb, mtr, rdn, wrn, sz, sg);
         run_op(ack_at, rdat, sc, rc, be_, mi, un, a, w, b, we, to);
         exp_sc = (!memop || misal) ? 0 : (ack_at == 0 ? 16 : ack_at);
         total++; if (to || sc != exp_sc || mi != misal) begin bad++; $display("FAIL rnd%0d_flow stall=%0d mis=%0d want %0d/%0d", it, sc, mi, exp_sc, misal); end
         if (!memop) begin
            total++; if ({aluResult1_OUT, writeRegister1_OUT, do_writeback1_OUT, MemtoReg1_OUT, Data_input1_OUT} !== {addr, rd, wb & v, mtr & v, 32'h0})
               begin bad++; $display("FAIL rnd%0d_pass alu=%h rd=%0d wb=%b mtr=%b want %h/%0d/%b/%b", it, aluResult1_OUT, writeRegister1_OUT, do_writeback1_OUT, MemtoReg1_OUT, addr, rd, wb & v, mtr & v); end
         end else if (misal || ack_at == 0) begin
            total++; if ({do_writeback1_OUT, MemtoReg1_OUT, Data_input1_OUT} !== 34'h0 || be_ != (!misal) || (misal && rc != 0))
               begin bad++; $display("FAIL rnd%0d_drop wb=%b buserr=%0d req=%0d", it, do_writeback1_OUT, be_, rc); end
         end else begin
            total++; if (a !== {addr[31:2], 2'b00} || we !== wrn || b !== exp_be(wrn, sz, addr) || w !== exp_wdata(wrn, sz, d) || un)
               begin bad++; $display("FAIL rnd%0d_bus addr=%h we=%b be=%b wdata=%h want %h/%b/%b/%h", it, a, we, b, w, {addr[31:2], 2'b00}, wrn, exp_be(wrn, sz, addr), exp_wdata(wrn, sz, d)); end
            total++; if ({aluResult1_OUT, writeRegister1_OUT, do_writeback1_OUT, MemtoReg1_OUT} !== {addr, rd, wb, mtr} ||
                         Data_input1_OUT !== (rdn ? exp_load(sz, sg, addr, rdat) : 32'h0))
               begin bad++; $display("FAIL rnd%0d_memwb alu=%h data=%h want %h/%h", it, aluResult1_OUT, Data_input1_OUT, addr, rdn ? exp_load(sz, sg, addr, rdat) : 32'h0); end
         end
         bubble();
      end
   endtask

   initial begin
      test_reset();
      test_alu_op();
      test_signed_byte_load();
      test_half_store();
      test_misalign();
      test_timeout();
      test_async_reset();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access stage of the 32-bit five-stage pipeline, directly upstream of the write-back stage.
- Takes the EX/MEM bundle and performs loads and stores over a req/ack data-memory port.
- Stalls the front of the pipeline while an access is outstanding.
- Produces the registered MEM/WB bundle (ALU result, aligned load data, destination register, MemtoReg, writeback enable) that write-back consumes.

Parameters:
- TIMEOUT, 16: max cycles in REQ awaiting dmem_ack before the access is aborted; 0 disables the watchdog.
- TO_W, 5: watchdog counter width; must hold TIMEOUT.

Ports:
- CLK  in  1  clock; all state updates on rising edge
- RESET  in  1  asynchronous, active-high reset
- valid_IN  in  1  EX/MEM bundle holds a real instruction (0 = bubble)
- aluResult1  in  32  ALU result; the byte address for memory operations
- data_write1  in  32  store data, right-justified
- writeRegister1  in  5  destination register
- do_writeback1  in  1  instruction writes the register file
- MemtoReg1  in  1  write-back selects load data
- MemRead1  in  1  load
- MemWrite1  in  1  store (MemRead1 and MemWrite1 are never both 1)
- mem_size1  in  2  00 byte, 01 half, 10 word; 11 is treated as word
- mem_signed1  in  1  sign-extend loaded byte/half
- STALL_OUT  out  1  freeze upstream stages; EX/MEM inputs are held stable while 1
- dmem_req  out  1  memory request, held until ack
- dmem_we  out  1  1 = store
- dmem_addr  out  32  word address, bits [1:0] = 0
- dmem_wdata  out  32  lane-replicated store data
- dmem_be  out  4  byte enables
- dmem_ack  in  1  access complete; dmem_rdata valid this cycle
- dmem_rdata  in  32  read word
- aluResult1_OUT  out  32  MEM/WB ALU result
- Data_input1_OUT  out  32  MEM/WB aligned, extended load data
- writeRegister1_OUT  out  5  MEM/WB destination register
- MemtoReg1_OUT  out  1  MEM/WB MemtoReg
- do_writeback1_OUT  out  1  MEM/WB writeback enable
- misalign_OUT  out  1  one-cycle pulse: misaligned access dropped
- bus_error_OUT  out  1  one-cycle pulse: watchdog abort

Behaviour:
- Reset (async, immediate): state IDLE, watchdog counter 0, every output 0, dmem_req drops at once. A transaction in flight is abandoned; memory must discard it.
- memop = valid_IN & (MemRead1 | MemWrite1). Misaligned = half with addr[0]=1, or word with addr[1:0]≠0.
- IDLE, no memop, or bubble: MEM/WB register captures the inputs each cycle; Data_input1_OUT=0. A bubble forces do_writeback1_OUT=0 and MemtoReg1_OUT=0. STALL_OUT=0. Latency is 1 cycle.
- IDLE, memop misaligned: no request is issued. MEM/WB captures a bubble (do_writeback=0, MemtoReg=0, others 0). misalign_OUT=1 for that cycle. STALL_OUT=0.
- IDLE, memop aligned: STALL_OUT=1. dmem_we/addr/wdata/be are registered from the inputs. Next state REQ; counter cleared.
- REQ: dmem_req=1 with stable addr/we/wdata/be.
  - On dmem_ack: MEM/WB captures the inputs. Data_input1_OUT = aligned load data for a load, 0 for a store. STALL_OUT=0 that cycle so upstream advances. Next state IDLE.
  - Without ack: STALL_OUT=1 and the counter increments.
- Watchdog: when TIMEOUT≠0 and the counter reaches TIMEOUT-1 without ack, the access aborts. bus_error_OUT pulses, MEM/WB captures a bubble, STALL_OUT=0, dmem_req drops next cycle, state returns to IDLE. If ack and terminal count coincide, ack wins and completes normally.
- Minimum aligned access: 2 cycles (accept in IDLE, ack in first REQ cycle). Back-to-back accesses: each re-enters IDLE for one cycle.
- Store lanes:
  - byte: wdata = {4{d[7:0]}}, be = 0001 << addr[1:0]
  - half: wdata = {2{d[15:0]}}, be = addr[1] ? 1100 : 0011
  - word: wdata = d, be = 1111
  - loads drive be = 1111, wdata = 0
- Load extraction: byte = rdata[8*addr[1:0] +: 8]; half = rdata[16*addr[1] +: 16]; extend with sign if mem_signed1, else with zero.
- dmem_ack while in IDLE is ignored.

Decomposition:
- Shared package mem_pkg holds:
  - size encodings SZ_BYTE/SZ_HALF/SZ_WORD
  - the state typedef (IDLE, REQ)
  - byte-enable constants
- Sub-module mem_lane_align (combinational): store be/wdata generation, load lane extraction and extension, misalign detect.
- FSM, watchdog and MEM/WB register stay in mem_stage.

Test Plan:
- ALU op (valid=1, no memop, aluResult1=0x1234, reg 5, wb=1) -> next edge: aluResult1_OUT=0x1234, writeRegister1_OUT=5, do_writeback1_OUT=1, STALL_OUT never asserted.
- Signed byte load at 0x1003, ack in first REQ cycle, rdata=0x80AABBCC -> dmem_addr=0x1000, be=1111, STALL_OUT 1 for exactly 1 cycle, Data_input1_OUT=0xFFFFFF80.
- Half store, data 0xBEEF at 0x2002, ack after 3 REQ cycles -> dmem_wdata=0xBEEFBEEF, be=1100, we=1, STALL_OUT high 4 cycles, do_writeback1_OUT=0.
- Word load at 0x3001 -> no dmem_req, misalign_OUT pulse, MEM/WB bubble, no stall.
- Load with no ack, TIMEOUT=16 -> bus_error_OUT pulses on 16th REQ cycle, dmem_req low the next cycle, bubble in MEM/WB; repeat with ack on 16th cycle -> normal completion, no bus_error.
- RESET asserted mid-REQ (asynchronously, between edges) -> dmem_req and all outputs 0 immediately; after release, IDLE and a fresh load completes.
